// File: rtl/op_datapath.sv
// Register-file datapath: single-cycle copy/load/add/sub, a 16-cycle shift-add multiplier,
// a sticky overflow flag and a free-running sample counter.
module op_datapath (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [2:0]  op,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic [3:0]  dest,
  input  logic [15:0] ext_data1,
  input  logic [15:0] ext_data2,
  input  logic        clear,
  input  logic        cnt_up,
  output logic        busy,
  output logic        overflow,
  output logic        err,
  output logic [15:0] result,
  output logic [9:0]  sample_count
);

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpCopy  = 3'd1;
  localparam logic [2:0] OpLoad1 = 3'd2;
  localparam logic [2:0] OpLoad2 = 3'd3;
  localparam logic [2:0] OpAdd   = 3'd4;
  localparam logic [2:0] OpSub   = 3'd5;
  localparam logic [2:0] OpMul   = 3'd6;
  localparam logic [2:0] OpRsvd  = 3'd7;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMult = 1'b1;

  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [0:0]  state_q, state_d;
  logic [4:0]  cyc_q, cyc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] mplier_q, mplier_d;
  logic [3:0]  mdest_q, mdest_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic [9:0]  cnt_q, cnt_d;

  logic [15:0] opa, opb, diff;
  logic [16:0] sum;
  logic [31:0] acc_next;

  always_comb begin
    opa      = regs_q[src1];
    opb      = regs_q[src2];
    sum      = {1'b0, opa} + {1'b0, opb};
    diff     = opa - opb;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    regs_d   = regs_q;
    state_d  = state_q;
    cyc_d    = cyc_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mdest_d  = mdest_q;
    ovf_d    = ovf_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    if (clear) begin
      // Clear wins over any op or count strobe and abandons a multiply unwritten.
      for (int i = 0; i < 16; i++) regs_d[i] = '0;
      state_d = StIdle;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      if (cnt_up) cnt_d = cnt_q + 10'd1;
      unique case (state_q)
        StIdle: begin
          case (op)
            OpCopy:  regs_d[dest] = opa;
            OpLoad1: regs_d[dest] = ext_data1;
            OpLoad2: regs_d[dest] = ext_data2;
            OpAdd: begin
              regs_d[dest] = sum[15:0];
              if (sum[16]) ovf_d = 1'b1;
            end
            OpSub: begin
              regs_d[dest] = diff;
              if (opa < opb) ovf_d = 1'b1;
            end
            OpMul: begin
              state_d  = StMult;
              mcand_d  = {16'd0, opa};
              mplier_d = opb;
              acc_d    = '0;
              cyc_d    = '0;
              mdest_d  = dest;
            end
            OpRsvd:  err_d = 1'b1;
            default: ;
          endcase
        end
        StMult: begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cyc_d    = cyc_q + 5'd1;
          if (cyc_q == 5'd15) begin
            regs_d[mdest_q] = acc_next[15:0];
            if (|acc_next[31:16]) ovf_d = 1'b1;
            state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      state_q  <= StIdle;
      cyc_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mdest_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      regs_q   <= regs_d;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mdest_q  <= mdest_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy         = (state_q == StMult);
  assign overflow     = ovf_q;
  assign err          = err_q;
  assign result       = regs_q[0];
  assign sample_count = cnt_q;

endmodule

// File: tb/tb_op_datapath.sv
// Self-checking bench for op_datapath: directed scenarios plus a randomized run
// against an arithmetic reference model of the register file.
module tb_op_datapath;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [2:0]  op;
  logic [3:0]  src1, src2, dest;
  logic [15:0] ext_data1, ext_data2;
  logic        clear, cnt_up;
  logic        busy, overflow, err;
  logic [15:0] result;
  logic [9:0]  sample_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] m_regs [16];
  logic        m_ovf;
  int          m_cnt;

  op_datapath dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .op           (op),
    .src1         (src1),
    .src2         (src2),
    .dest         (dest),
    .ext_data1    (ext_data1),
    .ext_data2    (ext_data2),
    .clear        (clear),
    .cnt_up       (cnt_up),
    .busy         (busy),
    .overflow     (overflow),
    .err          (err),
    .result       (result),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
    op = o; src1 = s1; src2 = s2; dest = d; ext_data1 = e1; ext_data2 = e2;
  endtask

  task automatic cmd(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
    drive(o, s1, s2, d, e1, e2);
    tick();
    op = 3'd0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  // Whole-operation reference: unsigned integer arithmetic on pre-op register values.
  task automatic model_exec(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] d, input logic [15:0] e1, input logic [15:0] e2);
    longint a, b, r;
    a = longint'(m_regs[s1]);
    b = longint'(m_regs[s2]);
    case (o)
      3'd1: m_regs[d] = m_regs[s1];
      3'd2: m_regs[d] = e1;
      3'd3: m_regs[d] = e2;
      3'd4: begin r = a + b; if (r > 65535) m_ovf = 1'b1; m_regs[d] = 16'(r); end
      3'd5: begin r = a - b; if (a < b) m_ovf = 1'b1; m_regs[d] = 16'(r); end
      3'd6: begin r = a * b; if (r > 65535) m_ovf = 1'b1; m_regs[d] = 16'(r); end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    drive(3'd0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
    clear = 1'b0; cnt_up = 1'b0;
    #12;
    n_cmp += 5;
    if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    if (sample_count !== 10'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", sample_count);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    model_clear();
  endtask

  task automatic test_load_add();
    cmd(3'd2, 4'd0, 4'd0, 4'd3, 16'h0005, 16'h0);
    cmd(3'd3, 4'd0, 4'd0, 4'd4, 16'h0, 16'h0007);
    cmd(3'd4, 4'd3, 4'd4, 4'd0, 16'h0, 16'h0);
    n_cmp += 2;
    if (result !== 16'h000C) begin n_fail++; $display("FAIL add_result: got %h want 000c", result); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_mul_overflow();
    int busy_cycles;
    do_clear();
    cmd(3'd2, 4'd0, 4'd0, 4'd3, 16'h0100, 16'h0);
    cmd(3'd3, 4'd0, 4'd0, 4'd4, 16'h0, 16'h0100);
    cmd(3'd6, 4'd3, 4'd4, 4'd0, 16'h0, 16'h0);
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      busy_cycles++;
      tick();
    end
    n_cmp += 4;
    if (busy_cycles != 16) begin
      n_fail++; $display("FAIL mul_busy_len: got %0d want 16", busy_cycles);
    end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end: got %b want 0", busy); end
    if (result !== 16'h0000) begin n_fail++; $display("FAIL mul_result: got %h want 0000", result); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL mul_ovf: got %b want 1", overflow); end
  endtask

  task automatic test_mul_ignore();
    int early;
    do_clear();
    cmd(3'd2, 4'd0, 4'd0, 4'd3, 16'h0003, 16'h0);
    cmd(3'd3, 4'd0, 4'd0, 4'd4, 16'h0, 16'h0004);
    cmd(3'd6, 4'd3, 4'd4, 4'd0, 16'h0, 16'h0);
    early = 0;
    for (int i = 0; i < 16; i++) begin
      drive(3'd4, 4'd3, 4'd4, (i % 2 == 0) ? 4'd0 : 4'd3, 16'h0, 16'h0);
      if (result !== 16'h0) early++;
      tick();
    end
    op = 3'd0;
    n_cmp += 4;
    if (early != 0) begin n_fail++; $display("FAIL mul_ign_during: got %0d writes want 0", early); end
    if (result !== 16'h000C) begin n_fail++; $display("FAIL mul_ign_result: got %h want 000c", result); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL mul_ign_ovf: got %b want 0", overflow); end
    cmd(3'd1, 4'd3, 4'd0, 4'd0, 16'h0, 16'h0);
    if (result !== 16'h0003) begin n_fail++; $display("FAIL mul_ign_reg3: got %h want 0003", result); end
  endtask

  task automatic test_sub_sticky();
    int drops;
    do_clear();
    cmd(3'd2, 4'd0, 4'd0, 4'd1, 16'h0002, 16'h0);
    cmd(3'd3, 4'd0, 4'd0, 4'd2, 16'h0, 16'h0005);
    cmd(3'd5, 4'd1, 4'd2, 4'd0, 16'h0, 16'h0);
    n_cmp += 5;
    if (result !== 16'hFFFD) begin n_fail++; $display("FAIL sub_result: got %h want fffd", result); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: got %b want 1", overflow); end
    drops = 0;
    for (int i = 0; i < 6; i++) begin
      cmd(3'd0, 4'(i), 4'(i), 4'(i), 16'hFFFF, 16'hFFFF);
      if (overflow !== 1'b1) drops++;
    end
    if (drops != 0) begin n_fail++; $display("FAIL sub_sticky: got %0d drops want 0", drops); end
    do_clear();
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL sub_clear_ovf: got %b want 1'b0", overflow); end
    if (result !== 16'h0) begin n_fail++; $display("FAIL sub_clear_res: got %h want 0000", result); end
  endtask

  task automatic test_clear_mid_mul();
    int nonzero;
    for (int i = 0; i < 16; i++) cmd(3'd2, 4'd0, 4'd0, 4'(i), 16'(i * 16'h0111 + 16'h0009), 16'h0);
    cmd(3'd4, 4'd15, 4'd15, 4'd14, 16'h0, 16'h0);
    cmd(3'd6, 4'd5, 4'd6, 4'd0, 16'h0, 16'h0);
    for (int i = 0; i < 7; i++) tick();
    clear = 1'b1;
    cnt_up = 1'b1;
    drive(3'd1, 4'd5, 4'd0, 4'd0, 16'h0, 16'h0);
    tick();
    clear = 1'b0; cnt_up = 1'b0; op = 3'd0;
    model_clear();
    n_cmp += 5;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", busy); end
    if (result !== 16'h0) begin n_fail++; $display("FAIL clr_result: got %h want 0000", result); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", overflow); end
    if (sample_count !== 10'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", sample_count); end
    for (int i = 0; i < 20; i++) tick();
    nonzero = 0;
    for (int i = 0; i < 16; i++) begin
      cmd(3'd1, 4'(i), 4'd0, 4'd0, 16'h0, 16'h0);
      if (result !== 16'h0) nonzero++;
    end
    if (nonzero != 0) begin n_fail++; $display("FAIL clr_regs: got %0d nonzero want 0", nonzero); end
  endtask

  task automatic test_count();
    do_clear();
    cnt_up = 1'b1;
    for (int i = 0; i < 1023; i++) tick();
    n_cmp += 4;
    if (sample_count !== 10'd1023) begin
      n_fail++; $display("FAIL cnt_1023: got %0d want 1023", sample_count);
    end
    tick();
    if (sample_count !== 10'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0d want 0", sample_count); end
    tick();
    cnt_up = 1'b0;
    if (sample_count !== 10'd1) begin n_fail++; $display("FAIL cnt_1025: got %0d want 1", sample_count); end
    cnt_up = 1'b1; clear = 1'b1;
    tick();
    cnt_up = 1'b0; clear = 1'b0;
    model_clear();
    if (sample_count !== 10'd0) begin
      n_fail++; $display("FAIL cnt_clear_wins: got %0d want 0", sample_count);
    end
  endtask

  task automatic test_err();
    int errs;
    cmd(3'd2, 4'd0, 4'd0, 4'd0, 16'h1234, 16'h0);
    cmd(3'd7, 4'd0, 4'd0, 4'd0, 16'hFFFF, 16'hFFFF);
    n_cmp += 4;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", err); end
    if (result !== 16'h1234) begin n_fail++; $display("FAIL err_nochange: got %h want 1234", result); end
    tick();
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", err); end
    cmd(3'd6, 4'd0, 4'd0, 4'd1, 16'h0, 16'h0);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      drive(3'd7, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
      tick();
      if (err !== 1'b0) errs++;
    end
    op = 3'd0;
    if (errs != 0) begin n_fail++; $display("FAIL err_while_busy: got %0d pulses want 0", errs); end
  endtask

  task automatic test_reset_mid_mul();
    do_clear();
    cmd(3'd2, 4'd0, 4'd0, 4'd1, 16'h0001, 16'h0);
    cmd(3'd3, 4'd0, 4'd0, 4'd2, 16'h0, 16'h0009);
    cmd(3'd5, 4'd1, 4'd2, 4'd3, 16'h0, 16'h0);
    cnt_up = 1'b1;
    cmd(3'd2, 4'd0, 4'd0, 4'd0, 16'h0077, 16'h0);
    cnt_up = 1'b0;
    cmd(3'd6, 4'd2, 4'd2, 4'd0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) tick();
    #2;
    n_reset = 1'b0;
    #1;
    n_cmp += 7;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mul_busy: got %b want 0", busy); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mul_ovf: got %b want 0", overflow); end
    if (result !== 16'h0) begin n_fail++; $display("FAIL rst_mul_result: got %h want 0000", result); end
    if (sample_count !== 10'd0) begin
      n_fail++; $display("FAIL rst_mul_count: got %0d want 0", sample_count);
    end
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mul_err: got %b want 0", err); end
    @(posedge clk); #1;
    n_reset = 1'b1;
    model_clear();
    cmd(3'd2, 4'd0, 4'd0, 4'd0, 16'hABCD, 16'h0);
    if (result !== 16'hABCD) begin n_fail++; $display("FAIL rst_first_cmd: got %h want abcd", result); end
    for (int i = 0; i < 20; i++) tick();
    if (result !== 16'hABCD) begin n_fail++; $display("FAIL rst_no_write: got %h want abcd", result); end
    m_regs[0] = 16'hABCD;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [3:0]  s1, s2, d;
    logic [15:0] e1, e2, prev_res;
    logic        prev_ovf;
    do_clear();
    for (int it = 0; it < 300; it++) begin
      o  = 3'($urandom_range(7));
      s1 = 4'($urandom_range(15));
      s2 = 4'($urandom_range(15));
      d  = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
      e1 = 16'($urandom);
      e2 = ($urandom_range(3) == 0) ? 16'($urandom_range(15)) : 16'($urandom);
      cnt_up = 1'($urandom_range(1));
      if (cnt_up) m_cnt = (m_cnt + 1) % 1024;
      prev_res = m_regs[0];
      prev_ovf = m_ovf;
      model_exec(o, s1, s2, d, e1, e2);
      cmd(o, s1, s2, d, e1, e2);
      if (o == 3'd6) begin
        for (int k = 0; k < 16; k++) begin
          n_cmp += 3;
          if (busy !== 1'b1) begin n_fail++; $display("FAIL rnd_busy: it %0d got %b want 1", it, busy); end
          if (result !== prev_res) begin
            n_fail++; $display("FAIL rnd_busy_res: it %0d got %h want %h", it, result, prev_res);
          end
          if (overflow !== prev_ovf) begin
            n_fail++; $display("FAIL rnd_busy_ovf: it %0d got %b want %b", it, overflow, prev_ovf);
          end
          drive(3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                4'd0, 16'($urandom), 16'($urandom));
          cnt_up = 1'($urandom_range(1));
          if (cnt_up) m_cnt = (m_cnt + 1) % 1024;
          tick();
        end
        op = 3'd0;
      end
      cnt_up = 1'b0;
      n_cmp += 5;
      if (result !== m_regs[0]) begin
        n_fail++; $display("FAIL rnd_result: it %0d op %0d got %h want %h", it, o, result, m_regs[0]);
      end
      if (overflow !== m_ovf) begin
        n_fail++; $display("FAIL rnd_ovf: it %0d op %0d got %b want %b", it, o, overflow, m_ovf);
      end
      if (err !== (o == 3'd7 ? 1'b1 : 1'b0) && o != 3'd6) begin
        n_fail++; $display("FAIL rnd_err: it %0d op %0d got %b", it, o, err);
      end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle: it %0d got %b want 0", it, busy); end
      if (sample_count !== 10'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_count: it %0d got %0d want %0d", it, sample_count, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_mul_overflow();
    test_mul_ignore();
    test_sub_sticky();
    test_clear_mid_mul();
    test_count();
    test_err();
    test_reset_mid_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/op_datapath.md
OP_DATAPATH -- requirements
Module: op_datapath

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: n_reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: op  input  3  command code: 0 NOP, 1 COPY, 2 LOAD1, 3 LOAD2, 4 ADD, 5 SUB, 6 MUL, 7 reserved.
REQ-004 SHALL have ports: src1, src2, dest  input  4 each  register indices 0..15.
REQ-005 SHALL have ports: ext_data1, ext_data2  input  16 each  external sample and coefficient words.
REQ-006 SHALL have port: clear  input  1  synchronous clear of all state.
REQ-007 SHALL have port: cnt_up  input  1  sample counter increment strobe.
REQ-008 SHALL have port: busy  output  1  multiply in progress; new commands are ignored while high.
REQ-009 SHALL have port: overflow  output  1  sticky arithmetic overflow flag.
REQ-010 SHALL have port: err  output  1  one-cycle pulse on a reserved opcode.
REQ-011 SHALL have port: result  output  16  current contents of reg0.
REQ-012 SHALL have port: sample_count  output  10  number of cnt_up strobes since reset or clear.

Function
REQ-013 SHALL hold a 16-entry x 16-bit register file; all arithmetic SHALL be unsigned.
REQ-014 SHALL sample op, src1, src2, dest, ext_data1 and ext_data2 on a clk edge only when busy=0.
REQ-015 Single-cycle ops SHALL write dest at the sampling edge, with values visible the next cycle:
  - COPY: src1
  - LOAD1: ext_data1
  - LOAD2: ext_data2
  - ADD: src1+src2, low 16 bits
  - SUB: src1-src2, low 16 bits
REQ-016 Operand reads SHALL use pre-edge register values; dest equal to src1 or src2 SHALL be legal.
REQ-017 NOP SHALL change no register and no flag.
REQ-018 Overflow SHALL be set and held in these cases:
  - ADD: carry out of bit 15
  - SUB: src1<src2
  - MUL: any nonzero bit in the upper 16 bits of the 32-bit product
REQ-019 Overflow SHALL be cleared only by clear or reset.
REQ-020 MUL SHALL run as a two-state FSM, IDLE and MULT, using a shift-add sequencer with a 5-bit cycle counter.
REQ-021 MUL acceptance SHALL latch both operands and move the FSM from IDLE to MULT; busy SHALL be 1 from the next cycle.
REQ-022 MULT SHALL process one multiplier bit per cycle for 16 cycles.
REQ-023 On the 16th MULT edge, the low 16 product bits SHALL be written to dest, the overflow check SHALL be applied, and the FSM SHALL return to IDLE; busy SHALL therefore be high for exactly 16 cycles.
REQ-024 dest for MUL SHALL be latched at acceptance; register-file changes during MULT SHALL NOT affect the result.
REQ-025 While busy=1, op SHALL be ignored; no queuing SHALL occur and err SHALL NOT be raised.
REQ-026 op=7 accepted while busy=0 SHALL modify no state and SHALL pulse err for exactly one cycle.
REQ-027 clear=1 at an edge SHALL take effect at that edge and SHALL discard any op presented at the same edge:
  - zero all registers, overflow and sample_count
  - abort any MUL without writing, with busy=0 the next cycle
REQ-028 cnt_up=1 at an edge SHALL increment sample_count, wrapping from 1023 to 0.
REQ-029 cnt_up SHALL be independent of busy and op, and SHALL lose to clear when both are high.

Reset
REQ-030 n_reset=0 SHALL asynchronously zero all registers, result, overflow, sample_count, busy and err, and force the FSM to IDLE.
REQ-031 Reset asserted mid-MUL SHALL abandon the operation with no write.
REQ-032 The first command SHALL be accepted at the first clk edge after n_reset deasserts.

Verification
REQ-033 The bench SHALL cover LOAD1, ext_data1=0x0005, dest=3, then LOAD2, ext_data2=0x0007, dest=4, then ADD, src1=3, src2=4, dest=0 -> result=0x000C one cycle after the ADD edge, overflow=0.
REQ-034 The bench SHALL cover MUL of reg3=0x0100 by reg4=0x0100, dest=0 -> busy high for 16 cycles, then result=0x0000 and overflow=1.
REQ-035 The bench SHALL cover MUL of 0x0003 by 0x0004, with ADD commands driven during busy -> result=0x000C, and the ADD commands have no effect.
REQ-036 The bench SHALL cover SUB of 0x0002 minus 0x0005 -> dest=0xFFFD, overflow=1, and overflow stays 1 across later NOPs until clear.
REQ-037 The bench SHALL cover clear at MULT cycle 8, with op=COPY at the same edge -> all registers 0, busy=0 the next cycle, no write.
REQ-038 The bench SHALL cover 1025 cnt_up pulses -> sample_count=1; op=7 -> err high for exactly one cycle; n_reset pulse mid-MUL -> all outputs 0.
